// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one registered memory port between the
// pipeline MEM stage (core) and an external loader/debug requester (ext).
// Each access runs IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE.
// The core wins ties unless ext has already lost STARVE_MAX grants in a row.
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Owner encoding: 0 = core, 1 = ext
  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;
  logic              r_core_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic              r_ext_gnt;
  logic              r_ext_done;
  logic [DATA_W-1:0] r_ext_rdata;

  logic              w_starved;
  logic              w_grant_ext;
  logic              w_grant_core;
  logic              w_grant_any;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Arbitration and request mux: ext only wins a tie once it has been starved
  always_comb begin
    w_starved    = (r_starve_cnt == SC_W'(STARVE_MAX));
    w_grant_ext  = ext_req & (~core_req | w_starved);
    w_grant_core = core_req & ~w_grant_ext;
    w_grant_any  = core_req | ext_req;
    w_sel_we     = w_grant_ext ? ext_we    : core_we;
    w_sel_addr   = w_grant_ext ? ext_addr  : core_addr;
    w_sel_wdata  = w_grant_ext ? ext_wdata : core_wdata;
  end

  // Access sequencer: grant, issue strobe, count read latency, pulse completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_we          <= 1'b0;
      r_starve_cnt  <= '0;
      r_lat_cnt     <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_core_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_ext_gnt     <= 1'b0;
      r_ext_done    <= 1'b0;
      r_ext_rdata   <= '0;
    end else begin
      r_core_rvalid <= 1'b0;
      r_ext_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ext || !ext_req)
            r_starve_cnt <= '0;
          else if (w_grant_core && !w_starved)
            r_starve_cnt <= r_starve_cnt + 1'b1;
          if (w_grant_any) begin
            r_owner       <= w_grant_ext;
            r_we          <= w_sel_we;
            r_mem_rd      <= ~w_sel_we;
            r_mem_wr      <= w_sel_we;
            r_mem_addr    <= w_sel_addr;
            r_mem_wr_data <= w_sel_wdata;
            r_ext_gnt     <= w_grant_ext;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          if (r_we) begin
            r_ext_done <= r_owner;
            r_state    <= S_DONE;
          end else begin
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_owner) r_ext_rdata  <= mem_rd_data;
            else         r_core_rdata <= mem_rd_data;
            r_core_rvalid <= ~r_owner;
            r_ext_done    <= r_owner;
            r_state       <= S_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ext_gnt <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is released only in the core's DONE cycle; reset forces it to follow core_req
  assign core_stall  = core_req & (reset | ~((r_state == S_DONE) & ~r_owner));
  assign core_rvalid = r_core_rvalid;
  assign core_rdata  = r_core_rdata;
  assign ext_gnt     = r_ext_gnt;
  assign ext_done    = r_ext_done;
  assign ext_rdata   = r_ext_rdata;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with MEM_LAT=1 for the
// main scenarios and one with MEM_LAT=3 for the long-latency ext read.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;

  // MEM_LAT = 1 instance
  logic        core_req, core_we, core_stall, core_rvalid;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        ext_req, ext_we, ext_gnt, ext_done;
  logic [8:0]  ext_addr;
  logic [31:0] ext_wdata, ext_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  // MEM_LAT = 3 instance
  logic        core_req3, core_we3, core_stall3, core_rvalid3;
  logic [8:0]  core_addr3;
  logic [31:0] core_wdata3, core_rdata3;
  logic        ext_req3, ext_we3, ext_gnt3, ext_done3;
  logic [8:0]  ext_addr3;
  logic [31:0] ext_wdata3, ext_rdata3;
  logic        mem_rd3, mem_wr3;
  logic [8:0]  mem_addr3;
  logic [31:0] mem_wr_data3, mem_rd_data3;

  int n_vec;
  int n_err;

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .core_req(core_req3), .core_we(core_we3), .core_addr(core_addr3), .core_wdata(core_wdata3),
    .core_stall(core_stall3), .core_rvalid(core_rvalid3), .core_rdata(core_rdata3),
    .ext_req(ext_req3), .ext_we(ext_we3), .ext_addr(ext_addr3), .ext_wdata(ext_wdata3),
    .ext_gnt(ext_gnt3), .ext_done(ext_done3), .ext_rdata(ext_rdata3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_addr(mem_addr3), .mem_wr_data(mem_wr_data3),
    .mem_rd_data(mem_rd_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle and settle past the edge
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0;  ext_we = 1'b0;  ext_addr = '0;  ext_wdata = '0;
    mem_rd_data = '0;
    core_req3 = 1'b0; core_we3 = 1'b0; core_addr3 = '0; core_wdata3 = '0;
    ext_req3 = 1'b0;  ext_we3 = 1'b0;  ext_addr3 = '0;  ext_wdata3 = '0;
    mem_rd_data3 = '0;

    // Reset state
    nxt(); nxt();
    chk("rst_stall", {31'd0, core_stall}, 32'd1);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    chk("rst_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("rst_ext_done", {31'd0, ext_done}, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_ext_rdata", ext_rdata, 32'd0);
    core_req = 1'b0;
    reset = 1'b0;
    nxt();

    // Core write 0xDEADBEEF @0x010
    core_req = 1'b1; core_we = 1'b1; core_addr = 9'h010; core_wdata = 32'hDEADBEEF;
    #1 chk("wr_c0_stall", {31'd0, core_stall}, 32'd1);
    nxt();
    chk("wr_c1_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr_c1_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("wr_c1_addr", {23'd0, mem_addr}, 32'h010);
    chk("wr_c1_wdata", mem_wr_data, 32'hDEADBEEF);
    chk("wr_c1_stall", {31'd0, core_stall}, 32'd1);
    nxt();
    chk("wr_c2_stall", {31'd0, core_stall}, 32'd0);
    chk("wr_c2_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("wr_c2_rvalid", {31'd0, core_rvalid}, 32'd0);
    core_req = 1'b0;
    nxt();

    // Core read @0x020, data 0x12345678 in cycle 2
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h020;
    nxt();
    chk("rd_c1_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rd_c1_addr", {23'd0, mem_addr}, 32'h020);
    nxt();
    mem_rd_data = 32'h12345678;
    #1 chk("rd_c2_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rd_c2_stall", {31'd0, core_stall}, 32'd1);
    nxt();
    chk("rd_c3_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("rd_c3_rdata", core_rdata, 32'h12345678);
    chk("rd_c3_stall", {31'd0, core_stall}, 32'd0);
    core_req = 1'b0;
    mem_rd_data = '0;
    nxt();
    chk("rd_c4_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("rd_c4_rdata_hold", core_rdata, 32'h12345678);

    // Simultaneous core write and ext write: core first, ext next
    core_req = 1'b1; core_we = 1'b1; core_addr = 9'h030; core_wdata = 32'h00000001;
    ext_req = 1'b1;  ext_we = 1'b1;  ext_addr = 9'h040;  ext_wdata = 32'hCAFEF00D;
    nxt();
    chk("cc_c1_addr", {23'd0, mem_addr}, 32'h030);
    chk("cc_c1_gnt", {31'd0, ext_gnt}, 32'd0);
    nxt();
    chk("cc_c2_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("cc_c2_done", {31'd0, ext_done}, 32'd0);
    core_req = 1'b0;
    nxt();
    chk("cc_c3_gnt", {31'd0, ext_gnt}, 32'd0);
    nxt();
    chk("cc_c4_gnt", {31'd0, ext_gnt}, 32'd1);
    chk("cc_c4_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("cc_c4_addr", {23'd0, mem_addr}, 32'h040);
    chk("cc_c4_wdata", mem_wr_data, 32'hCAFEF00D);
    chk("cc_c4_done", {31'd0, ext_done}, 32'd0);
    nxt();
    chk("cc_c5_done", {31'd0, ext_done}, 32'd1);
    chk("cc_c5_gnt", {31'd0, ext_gnt}, 32'd1);
    ext_req = 1'b0;
    nxt();
    chk("cc_c6_done", {31'd0, ext_done}, 32'd0);
    chk("cc_c6_gnt", {31'd0, ext_gnt}, 32'd0);

    // Starvation bound: ext held, core back-to-back reads
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h060;
    ext_req = 1'b1;  ext_we = 1'b0;  ext_addr = 9'h050;
    for (int g = 0; g < 5; g++) begin
      nxt();
      chk($sformatf("sv_g%0d_mem_rd", g), {31'd0, mem_rd}, 32'd1);
      chk($sformatf("sv_g%0d_gnt", g), {31'd0, ext_gnt}, (g == 4) ? 32'd1 : 32'd0);
      chk($sformatf("sv_g%0d_addr", g), {23'd0, mem_addr}, (g == 4) ? 32'h050 : 32'h060);
      nxt();
      mem_rd_data = 32'hA0000000 + 32'(g);
      nxt();
      if (g < 4) begin
        chk($sformatf("sv_g%0d_rvalid", g), {31'd0, core_rvalid}, 32'd1);
        chk($sformatf("sv_g%0d_rdata", g), core_rdata, 32'hA0000000 + 32'(g));
      end else begin
        chk("sv_g4_done", {31'd0, ext_done}, 32'd1);
        chk("sv_g4_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("sv_g4_ext_rdata", ext_rdata, 32'hA0000004);
        chk("sv_g4_stall", {31'd0, core_stall}, 32'd1);
      end
      nxt();
    end
    // Starve count restarted: core wins the next tie
    nxt();
    chk("sv_g5_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("sv_g5_addr", {23'd0, mem_addr}, 32'h060);

    // Reset during WAIT of that core read
    nxt();
    reset = 1'b1;
    #1 chk("rw_stall_in_rst", {31'd0, core_stall}, 32'd1);
    nxt();
    chk("rw_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rw_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("rw_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("rw_core_rdata", core_rdata, 32'd0);
    reset = 1'b0; core_req = 1'b0; ext_req = 1'b0;
    nxt();
    chk("rw_idle_rvalid", {31'd0, core_rvalid}, 32'd0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h070;
    nxt();
    chk("rw2_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rw2_addr", {23'd0, mem_addr}, 32'h070);
    nxt();
    mem_rd_data = 32'h55AA55AA;
    nxt();
    chk("rw2_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("rw2_rdata", core_rdata, 32'h55AA55AA);
    core_req = 1'b0;
    nxt();

    // MEM_LAT=3: ext read, data sampled at ISSUE+3, done in cycle 5
    ext_req3 = 1'b1; ext_we3 = 1'b0; ext_addr3 = 9'h0AB;
    mem_rd_data3 = 32'hB0000000;
    for (int c = 1; c <= 6; c++) begin
      nxt();
      mem_rd_data3 = 32'hB0000000 + 32'(c);
      chk($sformatf("l3_c%0d_done", c), {31'd0, ext_done3}, (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("l3_c%0d_gnt", c), {31'd0, ext_gnt3}, (c <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("l3_c%0d_mem_rd", c), {31'd0, mem_rd3}, (c == 1) ? 32'd1 : 32'd0);
      if (c == 5) begin
        chk("l3_ext_rdata", ext_rdata3, 32'hB0000004);
        ext_req3 = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
